// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage plus the IF/ID pipeline register.
// Holds the PC, fetches over a variable-latency req/ack instruction port,
// honours hazard stalls and branch/jump redirects, and inserts NOP bubbles.
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_stall_cyc.
//
// Memory handshake: imem_req=1 means imem_addr is a live request and stays
// stable until the memory answers. imem_ack is meaningful only in a cycle
// where imem_req=1; that cycle completes the request and imem_rdata is
// valid. An ack while imem_req=0 is ignored.
module fetch_stage #(
    parameter int              LEN_INST = 32,
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [LEN_INST-1:0] imem_rdata,
    output logic [LEN_INST-1:0] if_id_inst,
    output logic [ADDR_W-1:0]   if_id_pc4,
    output logic                if_id_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         perf_fetched,
    output logic [31:0]         perf_stall_cyc
`endif
);

    // FETCH: request outstanding; HOLD: response parked while stalled;
    // DROP: waiting out a request made stale by a redirect.
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  started_q;
    logic [ADDR_W-1:0]     pc_q, pc_d;
    logic [ADDR_W-1:0]     req_addr_q, req_addr_d;
    logic [LEN_INST-1:0]   buf_inst_q, buf_inst_d;
    logic [ADDR_W-1:0]     buf_pc4_q, buf_pc4_d;
    logic [LEN_INST-1:0]   inst_q, inst_d;
    logic [ADDR_W-1:0]     pc4_q, pc4_d;
    logic                  valid_q, valid_d;
    logic                  wr_valid;
    logic                  ack_v;
    logic [ADDR_W-1:0]     req_pc4;
    logic [ADDR_W-1:0]     redirect_tgt;
    logic                  unused_bits;

    // No request in the first cycle after reset so a late ack for a
    // pre-reset request lands while imem_req=0 and is ignored.
    assign imem_req     = started_q && (state_q != S_HOLD);
    assign imem_addr    = req_addr_q;
    assign ack_v        = imem_req && imem_ack;
    assign req_pc4      = req_addr_q + ADDR_W'(4);
    assign redirect_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign unused_bits  = ^redirect_pc[1:0];

    assign if_id_inst   = inst_q;
    assign if_id_pc4    = pc4_q;
    assign if_id_valid  = valid_q;

    // Next-state, PC, hold buffer and IF/ID update; redirect beats stall.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        buf_inst_d = buf_inst_q;
        buf_pc4_d  = buf_pc4_q;
        inst_d     = inst_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        wr_valid   = 1'b0;

        if (redirect) begin
            inst_d     = '0;
            valid_d    = 1'b0;
            pc_d       = redirect_tgt;
            buf_inst_d = '0;
            buf_pc4_d  = '0;
            if (state_q == S_DROP) begin
                // Already discarding: only retarget; finish drop on ack.
                if (ack_v) begin
                    state_d    = S_FETCH;
                    req_addr_d = redirect_tgt;
                end
            end else if (state_q == S_FETCH && imem_req && !ack_v) begin
                // Keep the old request alive until memory answers it.
                state_d = S_DROP;
            end else begin
                state_d    = S_FETCH;
                req_addr_d = redirect_tgt;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (started_q) begin
                        if (ack_v) begin
                            if (stall) begin
                                buf_inst_d = imem_rdata;
                                buf_pc4_d  = req_pc4;
                                state_d    = S_HOLD;
                            end else begin
                                inst_d     = imem_rdata;
                                pc4_d      = req_pc4;
                                valid_d    = 1'b1;
                                wr_valid   = 1'b1;
                                pc_d       = req_pc4;
                                req_addr_d = req_pc4;
                            end
                        end else if (!stall) begin
                            inst_d  = '0;
                            valid_d = 1'b0;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        inst_d     = buf_inst_q;
                        pc4_d      = buf_pc4_q;
                        valid_d    = 1'b1;
                        wr_valid   = 1'b1;
                        pc_d       = buf_pc4_q;
                        req_addr_d = buf_pc4_q;
                        state_d    = S_FETCH;
                    end
                end
                S_DROP: begin
                    inst_d  = '0;
                    valid_d = 1'b0;
                    if (ack_v) begin
                        state_d    = S_FETCH;
                        req_addr_d = pc_q;
                    end
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    // State, PC, request address, hold buffer and IF/ID registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_FETCH;
            started_q  <= 1'b0;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            buf_inst_q <= '0;
            buf_pc4_q  <= '0;
            inst_q     <= '0;
            pc4_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            started_q  <= 1'b1;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            buf_inst_q <= buf_inst_d;
            buf_pc4_q  <= buf_pc4_d;
            inst_q     <= inst_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_stall_cyc_q;

    assign perf_fetched   = perf_fetched_q;
    assign perf_stall_cyc = perf_stall_cyc_q;

    // Count valid IF/ID writes and stalled cycles; both wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetched_q   <= '0;
            perf_stall_cyc_q <= '0;
        end else begin
            if (wr_valid) perf_fetched_q <= perf_fetched_q + 32'd1;
            if (stall)    perf_stall_cyc_q <= perf_stall_cyc_q + 32'd1;
        end
    end
`else
    logic unused_perf;
    assign unused_perf = wr_valid;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage with a latency-programmable
// instruction memory responder (rdata = {16'hC0DE, addr[15:0]}).
// Build with FETCH_PERF_EN defined to also check the perf counters.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall_cyc;
`endif

    int n_cmp;
    int n_err;
    int lat;
    int wait_cnt;

    fetch_stage #(
        .LEN_INST (32),
        .ADDR_W   (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_id_inst  (if_id_inst),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stall_cyc (perf_stall_cyc)
`endif
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: ack after 'lat' waiting cycles of a live request.
    always_comb begin
        imem_ack   = imem_req && (wait_cnt >= lat);
        imem_rdata = {16'hC0DE, imem_addr[15:0]};
    end

    // Wait counter restarts on every completed or absent request.
    always @(posedge clk) begin
        if (!rst || !imem_req || imem_ack) wait_cnt <= 0;
        else                               wait_cnt <= wait_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; lat = 0;

        // Reset
        tick(); tick();
        chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
        chk("rst_inst",  if_id_inst, 32'd0);
        chk("rst_pc4",   if_id_pc4, 32'd0);
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        rst = 1'b1;
        chk("rel_req0",  {31'd0, imem_req}, 32'd0);
        tick();
        chk("first_req",  {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        chk("first_val",  {31'd0, if_id_valid}, 32'd0);

        // Back-to-back single-cycle fetches
        tick();
        chk("b2b_pc4_4",  if_id_pc4, 32'h4);
        chk("b2b_inst_0", if_id_inst, 32'hC0DE0000);
        chk("b2b_val",    {31'd0, if_id_valid}, 32'd1);
        chk("b2b_addr_4", imem_addr, 32'h4);
        tick();
        chk("b2b_pc4_8",  if_id_pc4, 32'h8);
        tick();
        chk("b2b_pc4_c",  if_id_pc4, 32'hC);
        tick();
        chk("b2b_pc4_10", if_id_pc4, 32'h10);
        chk("b2b_addr10", imem_addr, 32'h10);

        // Latency 3: three bubbles, stable address
        lat = 3;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lat_bub_val",  {31'd0, if_id_valid}, 32'd0);
            chk("lat_bub_inst", if_id_inst, 32'd0);
            chk("lat_addr",     imem_addr, 32'h10);
        end
        tick();
        chk("lat_pc4",  if_id_pc4, 32'h14);
        chk("lat_inst", if_id_inst, 32'hC0DE0010);
        chk("lat_val",  {31'd0, if_id_valid}, 32'd1);

        // Stall 4 cycles with the ack landing in the last one
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stl_pc4",  if_id_pc4, 32'h14);
            chk("stl_val",  {31'd0, if_id_valid}, 32'd1);
            chk("stl_inst", if_id_inst, 32'hC0DE0010);
        end
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        stall = 1'b0;
        tick();
        chk("rel_pc4",  if_id_pc4, 32'h18);
        chk("rel_inst", if_id_inst, 32'hC0DE0014);
        chk("rel_val",  {31'd0, if_id_valid}, 32'd1);
        chk("rel_addr", imem_addr, 32'h18);
        lat = 0;
        tick();
        chk("next_pc4", if_id_pc4, 32'h1C);

        // Redirect with ack in the same cycle
        redirect = 1'b1; redirect_pc = 32'h8;
        tick();
        chk("rda_val",  {31'd0, if_id_valid}, 32'd0);
        chk("rda_inst", if_id_inst, 32'd0);
        chk("rda_addr", imem_addr, 32'h8);

        // Redirect to 0x40 while latency-3 request to 0x8 is outstanding
        redirect = 1'b0; lat = 3;
        tick();
        chk("wait8_val", {31'd0, if_id_valid}, 32'd0);
        redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        chk("drop_req",  {31'd0, imem_req}, 32'd1);
        chk("drop_addr", imem_addr, 32'h8);
        chk("drop_val",  {31'd0, if_id_valid}, 32'd0);
        redirect = 1'b0; stall = 1'b1;
        tick();
        chk("drop2_addr", imem_addr, 32'h8);
        chk("drop2_val",  {31'd0, if_id_valid}, 32'd0);
        tick();
        chk("tgt_addr", imem_addr, 32'h40);
        chk("tgt_val",  {31'd0, if_id_valid}, 32'd0);
        chk("tgt_inst", if_id_inst, 32'd0);
        stall = 1'b0; lat = 0;
        tick();
        chk("tgt_pc4",  if_id_pc4, 32'h44);
        chk("tgt_inst", if_id_inst, 32'hC0DE0040);
        chk("tgt_v1",   {31'd0, if_id_valid}, 32'd1);

        // Redirect and stall together, unaligned target
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h103;
        tick();
        chk("rs_val",  {31'd0, if_id_valid}, 32'd0);
        chk("rs_addr", imem_addr, 32'h100);
        stall = 1'b0; redirect = 1'b0;
        tick();
        chk("rs_pc4", if_id_pc4, 32'h104);
        chk("rs_v1",  {31'd0, if_id_valid}, 32'd1);

        // Address wrap
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
        redirect = 1'b0;
        tick();
        chk("wr_pc4",  if_id_pc4, 32'h0);
        chk("wr_inst", if_id_inst, 32'hC0DEFFFC);
        chk("wr_addr0", imem_addr, 32'h0);

        // Reset mid-operation, then 5 fetches and 2 stall cycles
        rst = 1'b0;
        tick();
        chk("mr_val",  {31'd0, if_id_valid}, 32'd0);
        chk("mr_inst", if_id_inst, 32'd0);
        chk("mr_pc4",  if_id_pc4, 32'd0);
        chk("mr_req",  {31'd0, imem_req}, 32'd0);
        rst = 1'b1;
        tick();
        chk("mr_req1", {31'd0, imem_req}, 32'd1);
        chk("mr_addr", imem_addr, 32'h0);
        for (int i = 0; i < 5; i++) tick();
        chk("mr_pc4_14", if_id_pc4, 32'h14);
        stall = 1'b1;
        tick();
        chk("mr_hold_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("mr_hold_pc4", if_id_pc4, 32'h14);
`ifdef FETCH_PERF_EN
        chk("perf_fetched",   perf_fetched, 32'd5);
        chk("perf_stall_cyc", perf_stall_cyc, 32'd2);
`endif
        stall = 1'b0;
        tick();
        chk("mr_rel_pc4",  if_id_pc4, 32'h18);
        chk("mr_rel_inst", if_id_inst, 32'hC0DE0014);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage with the IF/ID pipeline register, directly upstream of the instruction decoder/control unit.
- Holds the PC and fetches over a variable-latency req/ack instruction-memory port.
- Presents instruction, PC+4 and a valid bit to ID.
- Honours hazard-unit stalls and branch/jump redirects (PCSrc), inserting NOP bubbles where required.

Parameters:
- LEN_INST, 32, instruction width
- ADDR_W, 32, PC / address width
- RESET_PC, 0, PC value after reset

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  synchronous reset, active-low
- stall  in  1  hazard unit: hold IF/ID and PC
- redirect  in  1  taken branch/jump (PCSrc)
- redirect_pc  in  ADDR_W  branch/jump target
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address
- imem_ack  in  1  response valid this cycle
- imem_rdata  in  LEN_INST  fetched instruction
- if_id_inst  out  LEN_INST  instruction to decode
- if_id_pc4  out  ADDR_W  fetch address + 4
- if_id_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (rst=0 at a clk edge):
  - pc=RESET_PC, state=FETCH, imem_req=0, if_id_inst=0 (NOP), if_id_pc4=0, if_id_valid=0, hold buffer cleared.
  - First imem_req=1 appears in the cycle after rst is sampled high.
- Reset mid-operation: applies as above; an ack arriving during or after reset for a pre-reset request is ignored.
- States: FETCH, HOLD, DROP.
- FETCH:
  - imem_req=1; imem_addr comes from a req_addr register, stable until ack.
  - Ack and !stall: IF/ID <= {rdata, req_addr+4, valid=1}; pc <= req_addr+4; next request issues the following cycle. Single-cycle memory gives 1 instruction/cycle.
  - Ack and stall: rdata and addr+4 go to the hold buffer; state->HOLD; imem_req=0.
  - No ack and !stall: IF/ID <= bubble (inst=0, valid=0); pc4 is don't-care.
  - No ack and stall: IF/ID unchanged.
- HOLD:
  - imem_req=0.
  - When stall=0: IF/ID <= buffer, valid=1; pc <= buffered addr+4; state->FETCH.
- Redirect (highest priority, overrides stall):
  - IF/ID <= bubble; pc <= {redirect_pc[ADDR_W-1:2],2'b00}; hold buffer discarded.
  - Request outstanding (FETCH, no ack this cycle): state->DROP. imem_req stays 1 at the old address until ack, then the response is discarded, state->FETCH, and the target is requested the next cycle.
  - Ack in the same cycle as redirect: response discarded; state->FETCH on the target.
  - Redirect while in DROP: update pc only.
- Stall during DROP: no effect on the drop.
- In DROP and while redirect is high, IF/ID valid stays 0.
- Arithmetic: +4 is modulo 2^ADDR_W; 0xFFFFFFFC+4 = 0.
- Memory contract: imem_ack is only sampled while imem_req=1; ack with req=0 is ignored.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds outputs perf_fetched (32) and perf_stall_cyc (32).
  - perf_fetched increments on each instruction written to IF/ID with valid=1.
  - perf_stall_cyc increments on each cycle with stall=1 and rst=1.
  - Both clear on reset and wrap at 2^32.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset, RESET_PC=0, ack same cycle as req, rdata=addr-derived: addresses 0,4,8,C issued back-to-back; if_id_pc4 = 4,8,C,10; valid=1 from the cycle after the first ack; if_id_inst=0 and valid=0 while rst=0.
- Ack latency 3 cycles: each fetch shows 3 bubble cycles (valid=0, inst=0); imem_addr stable across the wait.
- Stall for 4 cycles, ack arriving during the stall: IF/ID unchanged for 4 cycles, imem_req=0 in HOLD; on release the buffered instruction appears with valid=1, then the fetch at +4.
- Redirect to 0x40 while a latency-3 request to 0x8 is outstanding: IF/ID flushed; the 0x8 response is dropped; the next request is to 0x40; the first valid if_id_pc4 = 0x44.
- Redirect and stall in the same cycle, redirect_pc=0x103: IF/ID flushed despite stall; next fetch address 0x100.
- PC 0xFFFFFFFC fetched: if_id_pc4=0, next fetch address 0. With FETCH_PERF_EN, 5 fetches plus 2 stall cycles give perf_fetched=5, perf_stall_cyc=2.
